// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word addresses to a 1-cycle memory,
// buffers returned words in a 2-entry FIFO and hands them to decode in program order.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] ADDR_STEP = 32'd1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_instruction,
    input  logic        fetch_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        decode_ready
);

    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc;
    logic        inflight;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic [1:0]  count;

    logic        pop;
    logic        issue;
    logic [2:0]  occ;
    logic        wr_idx;

    // occ is the FIFO occupancy after this edge; issuing only while occ <= 1
    // guarantees the returning word always has a free slot.
    always_comb begin
        pop    = instr_valid & decode_ready;
        occ    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue  = fetch_en & ~branch_taken & (occ <= 3'd1);
        wr_idx = count[1] | (count[0] & ~pop);
    end

    assign mem_address = fetch_pc;
    assign instr_valid = (count != 2'd0);
    assign instr_out   = instr_valid ? fifo_instr[0] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[0]    : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            count    <= '0;
        end else if (branch_taken) begin
            fetch_pc <= branch_target;
            inflight <= 1'b0;
            count    <= '0;
        end else begin
            inflight <= issue;
            count    <= occ[1:0];
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_STEP;
            end
            if (pop) begin
                fifo_instr[0] <= fifo_instr[1];
                fifo_pc[0]    <= fifo_pc[1];
            end
            // A simultaneous push into slot 0 overrides the shift above.
            if (inflight) begin
                fifo_instr[wr_idx] <= mem_instruction;
                fifo_pc[wr_idx]    <= inflight_pc;
            end
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Requester side of the instruction-memory port. It owns the program counter and drives a word address to the instruction memory, which returns the addressed word one clock edge later. It delivers the fetched instructions in program order to decode through a valid/ready handshake. It also applies branch redirects and flushes any wrong-path work.

## Interface
- RESET_PC, 32'd0, fetch address loaded on reset
- ADDR_STEP, 32'd1, PC increment per fetch (memory is word-indexed, one instruction per address)
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- mem_address  output  32  address to instruction memory; equals fetch_pc combinationally
- mem_instruction  input  32  memory data; equals MEM[address presented during the previous cycle]
- fetch_en  input  1  1 = new fetches may be issued; 0 = no new fetches, buffered instructions still drain
- branch_taken  input  1  redirect request, sampled each rising edge
- branch_target  input  32  new fetch address when branch_taken=1
- instr_valid  output  1  instr_out/instr_pc hold a valid instruction
- instr_out  output  32  instruction at FIFO head
- instr_pc  output  32  address the head instruction was fetched from
- decode_ready  input  1  decode accepts head this cycle

## Operation
- State: fetch_pc[31:0], inflight (1 bit), inflight_pc[31:0], 2-entry instruction FIFO {instr, pc} with count 0..2.
- pop = instr_valid & decode_ready.
- occ = count + inflight − pop.
- issue = fetch_en & ~branch_taken & (occ <= 1).
- Issue (at edge): inflight_pc <= fetch_pc, inflight <= 1, fetch_pc <= fetch_pc + ADDR_STEP (mod 2^32, 0xFFFFFFFF wraps to 0).
- No issue (at edge): inflight <= 0. mem_address stays at fetch_pc; the memory's re-read of that address is discarded.
- Capture: if inflight=1 in a cycle, {mem_instruction, inflight_pc} is pushed to the FIFO tail at that edge.
- Push and pop in the same cycle are allowed; count is unchanged. The issue rule guarantees count never exceeds 2, so no push is ever dropped.
- Outputs: instr_valid = (count != 0). instr_out/instr_pc = FIFO head when valid, 0 when count=0.
- Head is held stable while instr_valid & ~decode_ready.
- Redirect (branch_taken=1 at edge), highest priority: fetch_pc <= branch_target, count <= 0, inflight <= 0.
  - Any pop, push or issue that cycle is ignored.
  - The presented head counts as not consumed.
- Reset (reset_n=0 at edge) overrides everything: fetch_pc <= RESET_PC, count <= 0, inflight <= 0.
  - Reset mid-stall or mid-redirect discards all contents.

## Timing
- Reset values: mem_address = RESET_PC, instr_valid = 0, instr_out = 0, instr_pc = 0.
- Cycle 0 is the first cycle with reset_n=1:
  - address RESET_PC issued at edge 0;
  - captured at edge 1;
  - instr_valid=1 from cycle 2.
- Fetch-to-valid latency is 2 cycles. Sustained throughput is 1 instruction/cycle with decode_ready held 1.
- Redirect at edge k:
  - mem_address = branch_target in cycle k+1;
  - instr_valid=0 in cycles k+1 and k+2;
  - the target instruction is valid in cycle k+3.
- Stall: after decode_ready falls, the FIFO fills to 2 and issuing stops. On release, delivery resumes with no bubble.
- fetch_en=0: current buffered and in-flight entries still deliver. Restart on fetch_en=1 has 2-cycle latency.

## Test plan
- Bench memory model MEM[a] = 0xA000_0000 + a (registered, 1-cycle latency).
- Reset, then decode_ready=1 constant -> cycles 2,3,4 present (0xA0000000,pc 0), (0xA0000001,pc 1), (0xA0000002,pc 2); no gaps, no duplicates.
- decode_ready=0 for cycles 4–9, then 1 -> head stays (0xA0000002,2) while low; count peaks at 2; mem_address frozen at 4. After release: pcs 2,3,4,5 on consecutive cycles.
- branch_taken=1, branch_target=0x20 at edge where head is pc 3 (ready=1) -> pc 3 is not counted as accepted; valid low 2 cycles; next delivered (0xA0000020, pc 0x20), then 0x21.
- Wrap: branch_target=0xFFFFFFFF -> delivers pc 0xFFFFFFFF then pc 0x00000000.
- reset_n=0 for one edge while count=2 and inflight=1 -> next cycle instr_valid=0, mem_address=0; restart delivers pc 0 in cycle 2 after release.
- fetch_en=0 with ready=1 -> at most 2 further instructions delivered, then instr_valid=0 and mem_address constant. fetch_en=1 -> next pc delivered 2 cycles later.
